chroma_key_pipe: RTL and testbench

CHROMA_KEY_PIPE -- requirements
Module: chroma_key_pipe

---
 rtl/chroma_key_pipe_pkg.sv | 15 +
 rtl/chroma_key_pipe_if.sv | 26 ++
 rtl/chroma_key_pipe_mod360_12.sv | 26 ++
 rtl/chroma_key_pipe.sv | 145 ++++++++++++++
 tb/tb_chroma_key_pipe.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chroma_key_pipe_pkg.sv
// Shared constants and encodings for the chroma-key pipeline.
package chroma_key_pipe_pkg;

  localparam int          HUE_MAX       = 360;
  localparam int          ANTI_DIAG_OFS = 720;
  localparam logic [14:0] KEY_FILL      = 15'h7FFF;

  typedef enum logic [1:0] {
    BG_DIAG = 2'd0,  // row + col
    BG_ANTI = 2'd1,  // row - col + ANTI_DIAG_OFS
    BG_ROW  = 2'd2,
    BG_COL  = 2'd3
  } bg_sel_t;

endpackage

// File: rtl/chroma_key_pipe_if.sv
// Pixel stream bundle: qualified input beat plus the delayed, qualified output beat.
interface chroma_key_pipe_if #(
  parameter int COORD_W = 13
);

  logic               in_valid;
  logic               sof;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic [23:0]        pixel_in;
  logic [23:0]        pass_in;
  logic               out_valid;
  logic [23:0]        pixel_out;
  logic [23:0]        pass_thru;

  modport master (
    output in_valid, sof, row, col, pixel_in, pass_in,
    input  out_valid, pixel_out, pass_thru
  );

  modport slave (
    input  in_valid, sof, row, col, pixel_in, pass_in,
    output out_valid, pixel_out, pass_thru
  );

endinterface

// File: rtl/chroma_key_pipe_mod360_12.sv
// Combinational 12-bit modulo-360 by conditional subtraction of 2880, 1440, 720, 360.
module mod360_12
  import chroma_key_pipe_pkg::*;
(
  input  logic [11:0] x_i,
  output logic [8:0]  y_o
);

  localparam logic [11:0] M8 = 12'(HUE_MAX * 8);
  localparam logic [11:0] M4 = 12'(HUE_MAX * 4);
  localparam logic [10:0] M2 = 11'(HUE_MAX * 2);
  localparam logic [9:0]  M1 = 10'(HUE_MAX);

  logic [11:0] r8;
  logic [10:0] r4;
  logic [9:0]  r2;

  // Each step halves the remaining range, so the intermediate narrows by one bit.
  always_comb begin
    r8  = (x_i >= M8) ? x_i - M8 : x_i;
    r4  = 11'((r8 >= M4) ? r8 - M4 : r8);
    r2  = 10'((r4 >= M2) ? r4 - M2 : r4);
    y_o = 9'((r2 >= M1) ? r2 - M1 : r2);
  end

endmodule

// File: rtl/chroma_key_pipe.sv
// Two-stage HSV chroma keyer: stage 1 matches and forms the background sum,
// stage 2 reduces it modulo 360 and muxes the keyed pixel; also counts keyed pixels per frame.
module chroma_key_pipe
  import chroma_key_pipe_pkg::*;
#(
  parameter int COORD_W = 13,
  parameter int HUE_W   = 9,
  parameter int SAT_W   = 7,
  parameter int CNT_W   = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chroma_key_pipe_if.slave     s,
  input  logic                 key_en,
  input  logic [1:0]           bg_sel,
  input  logic [HUE_W-1:0]     hue_lo,
  input  logic [HUE_W-1:0]     hue_hi,
  input  logic [SAT_W-1:0]     sat_min,
  input  logic [3:0]           scroll_step,
  output logic [CNT_W-1:0]     key_count,
  output logic                 count_valid
);

  localparam int BW = COORD_W + 1;

  logic             sof_cap;
  logic             key_en_q, key_en_c;
  bg_sel_t          bg_sel_q, bg_sel_c;
  logic [HUE_W-1:0] hue_lo_q, hue_lo_c, hue_hi_q, hue_hi_c, hue;
  logic [SAT_W-1:0] sat_min_q, sat_min_c, sat;
  logic [8:0]       phase_q, phase_d;
  logic [9:0]       phase_sum;
  logic             in_win, key_hit;
  logic [BW-1:0]    base_full;
  logic [11:0]      sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, key_count_q;
  logic             count_valid_q;

  logic             v1_q, key1_q, out_valid_q;
  logic [11:0]      sum1_q;
  logic [23:0]      pix1_q, pass1_q, pixel_out_q, pass_thru_q;
  logic [8:0]       bg_hue;

  assign sof_cap = s.in_valid & s.sof;

  // The sof beat already belongs to the new frame: it sees freshly captured config and
  // the advanced phase. scroll_step is only consumed on that beat, so it needs no shadow.
  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    key_en_c  = sof_cap ? key_en            : key_en_q;
    bg_sel_c  = sof_cap ? bg_sel_t'(bg_sel) : bg_sel_q;
    hue_lo_c  = sof_cap ? hue_lo            : hue_lo_q;
    hue_hi_c  = sof_cap ? hue_hi            : hue_hi_q;
    sat_min_c = sof_cap ? sat_min           : sat_min_q;

    phase_sum = {1'b0, phase_q} + {6'd0, scroll_step};
    phase_d   = phase_q;
    if (sof_cap) begin
      phase_d = (phase_sum >= 10'(HUE_MAX)) ? 9'(phase_sum - 10'(HUE_MAX)) : phase_sum[8:0];
    end

    hue     = s.pixel_in[23 -: HUE_W];
    sat     = s.pixel_in[14 -: SAT_W];
    in_win  = (hue_lo_c <= hue_hi_c) ? (hue >= hue_lo_c && hue <= hue_hi_c)
                                     : (hue >= hue_lo_c || hue <= hue_hi_c);
    key_hit = key_en_c && (hue < HUE_W'(HUE_MAX)) && (sat >= sat_min_c) && in_win;

    base_full = BW'(s.col);
    case (bg_sel_c)
      BG_DIAG: base_full = BW'(s.row) + BW'(s.col);
      BG_ANTI: base_full = BW'(s.row) - BW'(s.col) + BW'(ANTI_DIAG_OFS);
      BG_ROW:  base_full = BW'(s.row);
      BG_COL:  base_full = BW'(s.col);
      default: base_full = BW'(s.col);
    endcase
    sum_d = 12'((base_full & BW'(11'h7FF)) + BW'(phase_d));

    cnt_d = cnt_q;
    if (sof_cap) begin
      cnt_d = CNT_W'(key_hit);
    end else if (s.in_valid && key_hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  mod360_12 u_mod360 (
    .x_i (sum1_q),
    .y_o (bg_hue)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_en_q      <= 1'b0;
      bg_sel_q      <= BG_DIAG;
      hue_lo_q      <= '0;
      hue_hi_q      <= '0;
      sat_min_q     <= '0;
      phase_q       <= '0;
      cnt_q         <= '0;
      key_count_q   <= '0;
      count_valid_q <= 1'b0;
      v1_q          <= 1'b0;
      key1_q        <= 1'b0;
      sum1_q        <= '0;
      pix1_q        <= '0;
      pass1_q       <= '0;
      out_valid_q   <= 1'b0;
      pixel_out_q   <= '0;
      pass_thru_q   <= '0;
    end else begin
      key_en_q      <= key_en_c;
      bg_sel_q      <= bg_sel_c;
      hue_lo_q      <= hue_lo_c;
      hue_hi_q      <= hue_hi_c;
      sat_min_q     <= sat_min_c;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      count_valid_q <= sof_cap;
      if (sof_cap) key_count_q <= cnt_q;

      v1_q <= s.in_valid;
      if (s.in_valid) begin
        pix1_q  <= s.pixel_in;
        pass1_q <= s.pass_in;
        key1_q  <= key_hit;
        sum1_q  <= sum_d;
      end

      // Bubbles clear out_valid but leave the data outputs holding the last beat.
      out_valid_q <= v1_q;
      if (v1_q) begin
        pixel_out_q <= key1_q ? {bg_hue, KEY_FILL} : pix1_q;
        pass_thru_q <= pass1_q;
      end
    end
  end

  assign s.out_valid  = out_valid_q;
  assign s.pixel_out  = pixel_out_q;
  assign s.pass_thru  = pass_thru_q;
  assign key_count    = key_count_q;
  assign count_valid  = count_valid_q;

endmodule

// File: tb/tb_chroma_key_pipe.sv
// Self-checking bench: directed scenarios plus random traffic compared every cycle
// against a frame-level behavioural model of the keyer.
`timescale 1ns/1ps
module tb_chroma_key_pipe;

  localparam int RING    = 16;
  localparam int CNT_MAX = (1 << 24) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_en;
  logic [1:0]  bg_sel;
  logic [8:0]  hue_lo, hue_hi;
  logic [6:0]  sat_min;
  logic [3:0]  scroll_step;
  logic [23:0] key_count;
  logic        count_valid;

  always #5 clk = ~clk;

  chroma_key_pipe_if #(.COORD_W(13)) ifc ();

  chroma_key_pipe #(.COORD_W(13), .HUE_W(9), .SAT_W(7), .CNT_W(24)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (ifc.slave),
    .key_en      (key_en),
    .bg_sel      (bg_sel),
    .hue_lo      (hue_lo),
    .hue_hi      (hue_hi),
    .sat_min     (sat_min),
    .scroll_step (scroll_step),
    .key_count   (key_count),
    .count_valid (count_valid)
  );

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  // Expected outputs indexed by the clock edge after which they must be visible.
  bit          exp_v    [RING];
  logic [23:0] exp_pix  [RING];
  logic [23:0] exp_pass [RING];
  bit          exp_cv   [RING];
  logic [23:0] exp_kc   [RING];

  // Frame-level model state.
  bit          m_key_en;
  int          m_bg_sel, m_lo, m_hi, m_smin, m_phase, m_cnt, m_kc;
  logic [23:0] m_last_pix, m_last_pass;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_match(int hue, int sat, int lo, int hi, int smin);
    if (hue >= 360 || sat < smin) return 1'b0;
    if (lo <= hi) return (hue >= lo) && (hue <= hi);
    return (hue >= lo) || (hue <= hi);
  endfunction

  function automatic int m_bg_hue(int sel, int r, int c, int ph);
    int base;
    case (sel)
      0:       base = r + c;
      1:       base = r - c + 720;
      2:       base = r;
      default: base = c;
    endcase
    base = ((base % 2048) + 2048) % 2048;
    return (base + ph) % 360;
  endfunction

  function automatic int m_phase_adv(int ph, int stp);
    return (ph + stp) % 360;
  endfunction

  task automatic model_reset();
    m_key_en = 1'b0; m_bg_sel = 0; m_lo = 0; m_hi = 0; m_smin = 0;
    m_phase = 0; m_cnt = 0; m_kc = 0;
    m_last_pix = '0; m_last_pass = '0;
    for (int i = 0; i < RING; i++) begin
      exp_v[i] = 1'b0; exp_pix[i] = '0; exp_pass[i] = '0; exp_cv[i] = 1'b0; exp_kc[i] = '0;
    end
  endtask

  // Drive one input beat, predict its effects, then advance one clock (returns at edge + 1ns).
  task automatic step(input bit v, input bit sf, input int r, input int c,
                      input logic [23:0] px, input logic [23:0] ps);
    int e1, e2;
    bit cv;
    e1 = (edge_n + 1) % RING;
    e2 = (edge_n + 2) % RING;
    ifc.in_valid = v;
    ifc.sof      = sf;
    ifc.row      = 13'(r);
    ifc.col      = 13'(c);
    ifc.pixel_in = px;
    ifc.pass_in  = ps;
    cv = 1'b0;
    if (v && sf) begin
      m_key_en = key_en;
      m_bg_sel = int'(bg_sel);
      m_lo     = int'(hue_lo);
      m_hi     = int'(hue_hi);
      m_smin   = int'(sat_min);
      m_phase  = m_phase_adv(m_phase, int'(scroll_step));
      m_kc     = m_cnt;
      m_cnt    = 0;
      cv       = 1'b1;
    end
    if (v) begin
      if (m_key_en && m_match(int'(px[23:15]), int'(px[14:8]), m_lo, m_hi, m_smin)) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        m_last_pix = {9'(m_bg_hue(m_bg_sel, r, c, m_phase)), 15'h7FFF};
      end else begin
        m_last_pix = px;
      end
      m_last_pass = ps;
    end
    exp_cv[e1]   = cv;
    exp_kc[e1]   = 24'(m_kc);
    exp_v[e2]    = v;
    exp_pix[e2]  = m_last_pix;
    exp_pass[e2] = m_last_pass;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 8191)),
         int'($urandom_range(0, 8191)), 24'($urandom), 24'($urandom));
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.sof      = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid",   32'(ifc.out_valid), 32'd0);
    check("rst_pixel_out",   32'(ifc.pixel_out), 32'd0);
    check("rst_key_count",   32'(key_count),     32'd0);
    check("rst_count_valid", 32'(count_valid),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_cfg(input bit ke, input int sel, input int lo, input int hi,
                         input int smin, input int stp);
    key_en = ke; bg_sel = 2'(sel); hue_lo = 9'(lo); hue_hi = 9'(hi);
    sat_min = 7'(smin); scroll_step = 4'(stp);
  endtask

  // Cycle-by-cycle comparison against the model.
  int ci;
  always @(negedge clk) begin
    if (chk_en) begin
      ci = edge_n % RING;
      check("out_valid",   32'(ifc.out_valid), 32'(exp_v[ci]));
      check("pixel_out",   32'(ifc.pixel_out), 32'(exp_pix[ci]));
      check("pass_thru",   32'(ifc.pass_thru), 32'(exp_pass[ci]));
      check("count_valid", 32'(count_valid),   32'(exp_cv[ci]));
      check("key_count",   32'(key_count),     32'(exp_kc[ci]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int ph;
    int hue;
    logic [23:0] px;

    // Pin the model itself with hand-computed values.
    check("pin_bg_row400",  32'(m_bg_hue(2, 400, 0, 0)),   32'd40);
    check("pin_bg_anti",    32'(m_bg_hue(1, 0, 1000, 0)),  32'd328);
    check("pin_phase_wrap", 32'(m_phase_adv(355, 8)),      32'd3);
    ph = 0;
    for (int i = 0; i < 46; i++) ph = m_phase_adv(ph, 8);
    check("pin_phase_46",   32'(ph),                        32'd8);
    check("pin_match_350",  32'(m_match(350, 0, 340, 20, 0)), 32'd1);
    check("pin_match_10",   32'(m_match(10, 0, 340, 20, 0)),  32'd1);
    check("pin_match_180",  32'(m_match(180, 0, 340, 20, 0)), 32'd0);
    check("pin_match_400",  32'(m_match(400, 0, 340, 20, 0)), 32'd0);
    check("pin_match_sat",  32'(m_match(120, 49, 90, 150, 50)), 32'd0);

    set_cfg(1'b0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    ifc.in_valid = 1'b0; ifc.sof = 1'b0; ifc.row = '0; ifc.col = '0;
    ifc.pixel_in = '0; ifc.pass_in = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk_en = 1'b1;

    // Basic key with phase 0, background from row; first sof reports an empty count.
    set_cfg(1'b1, 2, 90, 150, 50, 0);
    step(1'b1, 1'b1, 400, 0, {9'd120, 7'd60, 8'h33}, 24'hABCDEF);
    check("first_sof_count_valid", 32'(count_valid), 32'd1);
    check("first_sof_key_count",   32'(key_count),   32'd0);
    idle();
    check("key_row400_pixel", 32'(ifc.pixel_out), 32'h147FFF);
    check("key_row400_pass",  32'(ifc.pass_thru), 32'hABCDEF);
    check("key_row400_valid", 32'(ifc.out_valid), 32'd1);
    check("count_valid_pulse_end", 32'(count_valid), 32'd0);

    // Wrapping hue window.
    set_cfg(1'b1, 3, 340, 20, 0, 0);
    step(1'b1, 1'b1, 0, 7, {9'd350, 7'd5, 8'h11}, 24'h000001);
    idle();
    check("wrap_hue350", 32'(ifc.pixel_out), 32'h03FFFF);
    step(1'b1, 1'b0, 0, 9, {9'd10, 7'd5, 8'h11}, 24'h000002);
    idle();
    check("wrap_hue10", 32'(ifc.pixel_out), 32'h04FFFF);
    step(1'b1, 1'b0, 0, 9, {9'd180, 7'd5, 8'h22}, 24'h000003);
    idle();
    check("wrap_hue180", 32'(ifc.pixel_out), 32'h5A0522);
    step(1'b1, 1'b0, 0, 9, {9'd400, 7'd5, 8'h44}, 24'h000004);
    idle();
    check("wrap_hue400", 32'(ifc.pixel_out), 32'hC80544);

    // Phase scrolling across 46 frame starts.
    set_cfg(1'b1, 3, 0, 359, 0, 8);
    for (int i = 0; i < 46; i++) step(1'b1, 1'b1, 0, 0, {9'd100, 7'd0, 8'h00}, 24'(i));
    step(1'b1, 1'b0, 0, 0, {9'd100, 7'd0, 8'h00}, 24'h0000AA);
    idle();
    check("scroll_46_hue", 32'(ifc.pixel_out[23:15]), 32'd8);

    // Mid-frame config change has no effect until the next sof.
    set_cfg(1'b0, 2, 0, 359, 0, 0);
    step(1'b1, 1'b0, 100, 10, {9'd100, 7'd0, 8'h00}, 24'h0000BB);
    idle();
    check("midframe_cfg_ignored", 32'(ifc.pixel_out), 32'h097FFF);
    key_en = 1'b1;
    step(1'b1, 1'b1, 100, 10, {9'd100, 7'd0, 8'h00}, 24'h0000CC);
    idle();
    check("sof_cfg_applied", 32'(ifc.pixel_out), 32'h367FFF);

    // 1000 keyed pixels with bubbles.
    set_cfg(1'b1, 0, 0, 359, 0, 3);
    step(1'b1, 1'b1, 1, 1, {9'(300), 7'd9, 8'h01}, 24'h100000);
    for (int i = 1; i < 1000; i++) begin
      if ($urandom_range(0, 2) == 0) idle();
      step(1'b1, 1'b0, int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)),
           {9'($urandom_range(0, 359)), 7'($urandom), 8'($urandom)}, 24'($urandom));
    end
    step(1'b1, 1'b1, 2, 2, {9'd400, 7'd0, 8'h00}, 24'h200000);
    check("frame1000_count_valid", 32'(count_valid), 32'd1);
    check("frame1000_key_count",   32'(key_count),   32'd1000);
    idle();
    check("frame1000_pulse_end",   32'(count_valid), 32'd0);

    // Random traffic with random config changes.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_cfg(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 400)), int'($urandom_range(0, 400)),
                int'($urandom_range(0, 127)), int'($urandom_range(0, 15)));
      end
      hue = ($urandom_range(0, 3) == 0) ? int'($urandom_range(360, 511))
                                        : int'($urandom_range(0, 359));
      px = {9'(hue), 7'($urandom), 8'($urandom)};
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
           int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)), px, 24'($urandom));
    end

    // Reset with two pixels in flight.
    set_cfg(1'b1, 3, 0, 359, 0, 0);
    step(1'b1, 1'b1, 0, 5, {9'd50, 7'd1, 8'h01}, 24'h300001);
    step(1'b1, 1'b0, 0, 6, {9'd60, 7'd1, 8'h02}, 24'h300002);
    check("inflight_before_reset", 32'(ifc.out_valid), 32'd1);
    do_reset();
    repeat (4) idle();
    step(1'b1, 1'b0, 0, 5, {9'd100, 7'd3, 8'h55}, 24'h300003);
    idle();
    check("post_reset_no_key", 32'(ifc.pixel_out), 32'h320355);
    step(1'b1, 1'b1, 0, 5, {9'd100, 7'd3, 8'h55}, 24'h300004);
    check("post_reset_sof_count_valid", 32'(count_valid), 32'd1);
    check("post_reset_sof_key_count",   32'(key_count),   32'd0);
    repeat (4) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
